// File: rtl/encoder16_pkg.sv
// Shared constants and helpers for the 16-line round-robin event encoder.
package encoder16_pkg;

    localparam int N_LINES = 16;
    localparam int IDX_W   = 4;

    typedef logic [N_LINES-1:0] lines_t;
    typedef logic [IDX_W-1:0]   idx_t;

    // 4-to-16 select decode; the encoder output is its inverse.
    function automatic lines_t onehot16(input idx_t idx);
        lines_t one;
        one = 16'h0001;
        return one << idx;
    endfunction

endpackage

// File: rtl/encoder16_rr_pick16.sv
// Combinational round-robin search: first set bit of c at or above ptr, wrapping 15 -> 0.
module rr_pick16
    import encoder16_pkg::*;
(
    input  logic [N_LINES-1:0] c,
    input  logic [IDX_W-1:0]   ptr,
    output logic               any,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W-1:0] w_pos;
    logic             w_found;

    assign any = |c;

    // Walk the 16 positions starting at ptr; the first hit wins, idx stays 0 when c is empty.
    always_comb begin
        idx     = 4'd0;
        w_pos   = 4'd0;
        w_found = 1'b0;
        for (int k = 0; k < N_LINES; k++) begin
            w_pos = ptr + 4'(k);
            if (!w_found && c[w_pos]) begin
                idx     = w_pos;
                w_found = 1'b1;
            end else begin
                w_found = w_found;
            end
        end
    end

endmodule

// File: rtl/encoder16_rr.sv
// Pending-event register with a round-robin encoded output stage and valid/ready handshake.
module encoder16_rr
    import encoder16_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_LINES-1:0] req,
    input  logic               flush,
    output logic [IDX_W-1:0]   out_idx,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N_LINES-1:0] pending,
    output logic               merged
);

    lines_t r_pending;
    idx_t   r_out_idx;
    logic   r_out_valid;
    logic   r_merged;
    idx_t   r_ptr;

    logic   w_transfer;
    logic   w_load;
    lines_t w_clr;
    lines_t w_cand;
    logic   w_any;
    idx_t   w_idx;

    assign w_transfer = r_out_valid & out_ready;
    assign w_load     = ~r_out_valid | w_transfer;
    assign w_clr      = w_transfer ? onehot16(r_out_idx) : 16'h0000;
    // The accepted line is excluded from the next pick; same-cycle req only reaches pending.
    assign w_cand     = r_pending & ~w_clr;

    rr_pick16 u_pick (
        .c   (w_cand),
        .ptr (r_ptr),
        .any (w_any),
        .idx (w_idx)
    );

    // State update: reset beats flush, flush beats transfer and new requests.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending   <= 16'h0000;
            r_out_idx   <= 4'd0;
            r_out_valid <= 1'b0;
            r_merged    <= 1'b0;
            r_ptr       <= 4'd0;
        end else if (flush) begin
            r_pending   <= 16'h0000;
            r_out_idx   <= 4'd0;
            r_out_valid <= 1'b0;
            r_merged    <= 1'b0;
        end else begin
            r_pending <= w_cand | req;
            r_merged  <= |(req & r_pending);
            if (w_load) begin
                r_out_valid <= w_any;
                r_out_idx   <= w_any ? w_idx : 4'd0;
            end else begin
                r_out_valid <= r_out_valid;
                r_out_idx   <= r_out_idx;
            end
            if (w_transfer) begin
                r_ptr <= r_out_idx + 4'd1;
            end else begin
                r_ptr <= r_ptr;
            end
        end
    end

    assign out_idx   = r_out_idx;
    assign out_valid = r_out_valid;
    assign pending   = r_pending;
    assign merged    = r_merged;

endmodule

// File: tb/tb_encoder16_rr.sv
// Directed table-driven bench for encoder16_rr plus a full-drain sequence.
module tb_encoder16_rr;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] req;
    logic        flush;
    logic [3:0]  out_idx;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] pending;
    logic        merged;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        rst_n;
        logic        flush;
        logic [15:0] req;
        logic        rdy;
        logic        e_valid;
        logic [3:0]  e_idx;
        logic [15:0] e_pending;
        logic        e_merged;
    } vec_t;

    vec_t vecs[$];

    encoder16_rr dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .flush     (flush),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pending   (pending),
        .merged    (merged)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int row, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic add(input logic rn, input logic fl, input logic [15:0] rq, input logic rd,
                       input logic ev, input logic [3:0] ei, input logic [15:0] ep, input logic em);
        vec_t v;
        v.rst_n = rn; v.flush = fl; v.req = rq; v.rdy = rd;
        v.e_valid = ev; v.e_idx = ei; v.e_pending = ep; v.e_merged = em;
        vecs.push_back(v);
    endtask

    task automatic step(input logic rn, input logic fl, input logic [15:0] rq, input logic rd);
        rst_n = rn; flush = fl; req = rq; out_ready = rd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; req = 16'h0000; out_ready = 1'b0;

        // inputs applied before an edge -> outputs expected just after it
        add(1'b0,1'b0,16'h0000,1'b0, 1'b0,4'd0, 16'h0000,1'b0); // reset
        add(1'b1,1'b0,16'h0010,1'b0, 1'b0,4'd0, 16'h0010,1'b0);
        add(1'b1,1'b0,16'h0000,1'b0, 1'b1,4'd4, 16'h0010,1'b0); // 2-edge latency
        for (int i = 0; i < 5; i++)
            add(1'b1,1'b0,16'h0000,1'b0, 1'b1,4'd4, 16'h0010,1'b0); // held while !ready
        add(1'b1,1'b0,16'h0000,1'b1, 1'b0,4'd0, 16'h0000,1'b0);
        add(1'b0,1'b0,16'h0000,1'b0, 1'b0,4'd0, 16'h0000,1'b0);
        add(1'b1,1'b0,16'h8001,1'b1, 1'b0,4'd0, 16'h8001,1'b0);
        add(1'b1,1'b0,16'h0000,1'b1, 1'b1,4'd0, 16'h8001,1'b0);
        add(1'b1,1'b0,16'h0000,1'b1, 1'b1,4'd15,16'h8000,1'b0);
        add(1'b1,1'b0,16'h0000,1'b1, 1'b0,4'd0, 16'h0000,1'b0);
        add(1'b1,1'b0,16'h8002,1'b1, 1'b0,4'd0, 16'h8002,1'b0);
        add(1'b1,1'b0,16'h0000,1'b1, 1'b1,4'd1, 16'h8002,1'b0); // ptr wrapped to 0
        add(1'b1,1'b0,16'h0000,1'b0, 1'b1,4'd1, 16'h8002,1'b0);
        add(1'b1,1'b0,16'h0000,1'b1, 1'b1,4'd15,16'h8000,1'b0);
        add(1'b1,1'b0,16'h0000,1'b1, 1'b0,4'd0, 16'h0000,1'b0);
        add(1'b1,1'b0,16'h0008,1'b0, 1'b0,4'd0, 16'h0008,1'b0);
        add(1'b1,1'b0,16'h0000,1'b0, 1'b1,4'd3, 16'h0008,1'b0);
        add(1'b1,1'b0,16'h0008,1'b1, 1'b0,4'd0, 16'h0008,1'b1); // merge during transfer
        add(1'b1,1'b0,16'h0000,1'b1, 1'b1,4'd3, 16'h0008,1'b0);
        add(1'b1,1'b0,16'h0000,1'b1, 1'b0,4'd0, 16'h0000,1'b0);
        add(1'b1,1'b0,16'h0010,1'b0, 1'b0,4'd0, 16'h0010,1'b0);
        add(1'b1,1'b0,16'h0010,1'b0, 1'b1,4'd4, 16'h0010,1'b1);
        add(1'b1,1'b0,16'h0000,1'b0, 1'b1,4'd4, 16'h0010,1'b0);
        add(1'b1,1'b0,16'h00E0,1'b0, 1'b1,4'd4, 16'h00F0,1'b0);
        add(1'b1,1'b1,16'h0001,1'b1, 1'b0,4'd0, 16'h0000,1'b0); // flush
        add(1'b1,1'b0,16'h0000,1'b0, 1'b0,4'd0, 16'h0000,1'b0);
        add(1'b1,1'b0,16'h0090,1'b0, 1'b0,4'd0, 16'h0090,1'b0);
        add(1'b1,1'b0,16'h0000,1'b0, 1'b1,4'd4, 16'h0090,1'b0); // ptr kept at 4
        add(1'b1,1'b1,16'h0000,1'b0, 1'b0,4'd0, 16'h0000,1'b0);
        add(1'b1,1'b0,16'h0300,1'b0, 1'b0,4'd0, 16'h0300,1'b0);
        add(1'b1,1'b0,16'h0000,1'b0, 1'b1,4'd8, 16'h0300,1'b0);
        add(1'b0,1'b0,16'h0000,1'b1, 1'b0,4'd0, 16'h0000,1'b0); // reset mid-transfer
        add(1'b1,1'b0,16'h0000,1'b1, 1'b0,4'd0, 16'h0000,1'b0);
        add(1'b1,1'b0,16'h0000,1'b1, 1'b0,4'd0, 16'h0000,1'b0);
        add(1'b1,1'b0,16'h8002,1'b1, 1'b0,4'd0, 16'h8002,1'b0);
        add(1'b1,1'b0,16'h0000,1'b1, 1'b1,4'd1, 16'h8002,1'b0); // ptr back to 0
        add(1'b1,1'b0,16'h0000,1'b1, 1'b1,4'd15,16'h8000,1'b0);
        add(1'b1,1'b0,16'h0000,1'b1, 1'b0,4'd0, 16'h0000,1'b0);
        add(1'b0,1'b1,16'hFFFF,1'b1, 1'b0,4'd0, 16'h0000,1'b0); // reset beats everything
        add(1'b1,1'b0,16'h0004,1'b0, 1'b0,4'd0, 16'h0004,1'b0);
        add(1'b1,1'b0,16'h0000,1'b0, 1'b1,4'd2, 16'h0004,1'b0);
        add(1'b1,1'b0,16'h0000,1'b1, 1'b0,4'd0, 16'h0000,1'b0);

        foreach (vecs[i]) begin
            step(vecs[i].rst_n, vecs[i].flush, vecs[i].req, vecs[i].rdy);
            check("out_valid", i, {15'd0, out_valid}, {15'd0, vecs[i].e_valid});
            check("out_idx",   i, {12'd0, out_idx},   {12'd0, vecs[i].e_idx});
            check("pending",   i, pending,            vecs[i].e_pending);
            check("merged",    i, {15'd0, merged},    {15'd0, vecs[i].e_merged});
        end

        // full drain: all 16 lines in order at one per clock
        step(1'b0, 1'b0, 16'h0000, 1'b0);
        step(1'b1, 1'b0, 16'hFFFF, 1'b1);
        step(1'b1, 1'b0, 16'h0000, 1'b1);
        for (int k = 0; k < 16; k++) begin
            logic [15:0] exp_p;
            exp_p = 16'hFFFF;
            exp_p = exp_p << k;
            check("drain_valid",   100 + k, {15'd0, out_valid}, 16'h0001);
            check("drain_idx",     100 + k, {12'd0, out_idx},   16'(k));
            check("drain_pending", 100 + k, pending,            exp_p);
            step(1'b1, 1'b0, 16'h0000, 1'b1);
        end
        check("drain_end_valid",   116, {15'd0, out_valid}, 16'h0000);
        check("drain_end_pending", 116, pending,            16'h0000);
        check("drain_end_merged",  116, {15'd0, merged},    16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
